// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcode encoding and FSM states.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/Nbit_ALU.sv
// Combinational N-bit ALU shared by the team; the reserved opcode yields 0.
module Nbit_ALU
    import alu_pkg::*;
#(
    parameter int n = 32
) (
    input  logic [n-1:0] r2,
    input  logic [n-1:0] r3,
    input  logic [2:0]   ALUop,
    output logic [n-1:0] r1
);

    logic [n-1:0] diff;

    assign diff = r2 - r3;

    always_comb begin
        r1 = '0;
        case (ALUop)
            OP_AND:  r1 = r2 & r3;
            OP_OR:   r1 = r2 | r3;
            OP_ADD:  r1 = r2 + r3;
            OP_SUB:  r1 = diff;
            OP_XOR:  r1 = r2 ^ r3;
            OP_NOR:  r1 = ~(r2 | r3);
            OP_SLT:  r1 = {{(n-1){1'b0}}, diff[n-1]};
            default: r1 = '0;
        endcase
    end

endmodule

// File: rtl/alu_regfile.sv
// Register file: two combinational operand reads, a debug read, one synchronous
// write. Entry 0 is hardwired to zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int N      = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [N-1:0]      wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [N-1:0]      rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [N-1:0]      rdata_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [N-1:0]      dbg_data
);

    localparam int DEPTH = 2 ** REG_AW;

    logic [N-1:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Gate address 0 on the read side too, so reg 0 is zero by construction.
    assign rdata_a  = (raddr_a  == '0) ? '0 : regs[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : regs[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one 3-operand instruction at a time to an external combinational ALU,
// writes the result back to the register file and reports completion.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int N      = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [2:0]        ins_op,
    input  logic [REG_AW-1:0] ins_rd,
    input  logic [REG_AW-1:0] ins_rs,
    input  logic [REG_AW-1:0] ins_rt,
    output logic [N-1:0]      alu_r2,
    output logic [N-1:0]      alu_r3,
    output logic [2:0]        alu_op,
    input  logic [N-1:0]      alu_r1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_data,
    output logic              rsp_err,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [N-1:0]      dbg_data
);

    state_t            state, state_next;
    logic [2:0]        op_lat;
    logic [REG_AW-1:0] rd_lat;
    logic [N-1:0]      src_a, src_b;
    logic [N-1:0]      result;
    logic              err;
    logic              accept;
    logic              rsvd;
    logic              wb_en;

    // Operand ports are addressed straight from the request so they can be
    // registered onto the ALU inputs on the accept edge.
    alu_regfile #(
        .N      (N),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wb_en),
        .waddr    (rd_lat),
        .wdata    (alu_r1),
        .raddr_a  (ins_rs),
        .rdata_a  (src_a),
        .raddr_b  (ins_rt),
        .rdata_b  (src_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign ins_ready = rst_n && (state == IDLE);
    assign accept    = ins_valid && ins_ready;
    assign rsvd      = (op_lat == OP_RSVD);
    assign wb_en     = (state == EXEC) && !rsvd;
    assign rsp_valid = (state == RESP);
    assign rsp_data  = result;
    assign rsp_err   = err;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_lat <= OP_AND;
            rd_lat <= '0;
            alu_r2 <= '0;
            alu_r3 <= '0;
            alu_op <= OP_AND;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_lat <= ins_op;
                rd_lat <= ins_rd;
                alu_r2 <= src_a;
                alu_r3 <= src_b;
                alu_op <= ins_op;
            end
            // Result and error flag are frozen from EXEC until the next EXEC,
            // which keeps the response stable under backpressure.
            if (state == EXEC) begin
                result <= rsvd ? '0 : alu_r1;
                err    <= rsvd;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed plus randomized bench for alu_issue_ctrl driving the real Nbit_ALU.
module tb_alu_issue_ctrl;

    localparam int N      = 32;
    localparam int REG_AW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ins_valid;
    logic              ins_ready;
    logic [2:0]        ins_op;
    logic [REG_AW-1:0] ins_rd, ins_rs, ins_rt;
    logic [N-1:0]      alu_r2, alu_r3, alu_r1;
    logic [2:0]        alu_op;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [N-1:0]      rsp_data;
    logic [REG_AW-1:0] dbg_addr;
    logic [N-1:0]      dbg_data;

    int n_total = 0;
    int n_pass  = 0;

    logic [N-1:0] model [8];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.N(N), .REG_AW(REG_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_op    (ins_op),
        .ins_rd    (ins_rd),
        .ins_rs    (ins_rs),
        .ins_rt    (ins_rt),
        .alu_r2    (alu_r2),
        .alu_r3    (alu_r3),
        .alu_op    (alu_op),
        .alu_r1    (alu_r1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    Nbit_ALU #(.n(N)) u_alu (
        .r2    (alu_r2),
        .r3    (alu_r3),
        .ALUop (alu_op),
        .r1    (alu_r1)
    );

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic logic [N-1:0] alu_ref(input logic [2:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        longint unsigned ua, ub, m;
        m  = 64'd1 << N;
        ua = a;
        ub = b;
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return N'((ua + ub) % m);
            3'd3: return N'((ua + m - ub) % m);
            3'd4: return a ^ b;
            3'd5: return ~(a | b);
            3'd6: return (((ua + m - ub) % m) >= (m / 2)) ? N'(1) : N'(0);
            default: return '0;
        endcase
    endfunction

    task automatic dbg_chk(input string tag, input logic [REG_AW-1:0] addr, input logic [N-1:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Called at a negedge while the DUT is idle; returns at negedge+1 of the next idle cycle.
    task automatic run_ins(input logic [2:0] op, input logic [REG_AW-1:0] rd,
                           input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                           input int hold);
        logic [N-1:0] a, b, exp;
        logic         err;
        a   = model[rs];
        b   = model[rt];
        err = (op == 3'b111);
        exp = err ? '0 : alu_ref(op, a, b);
        check("ready_idle", N'(ins_ready), N'(1));
        ins_valid = 1'b1; ins_op = op; ins_rd = rd; ins_rs = rs; ins_rt = rt;
        @(posedge clk); @(negedge clk);
        ins_valid = 1'b0; ins_op = 3'($urandom); ins_rs = 3'($urandom); ins_rt = 3'($urandom);
        check("issue_r2", alu_r2, a);
        check("issue_r3", alu_r3, b);
        check("issue_op", N'(alu_op), N'(op));
        check("issue_vld", N'(rsp_valid), N'(0));
        check("issue_rdy", N'(ins_ready), N'(0));
        @(negedge clk);
        check("exec_vld", N'(rsp_valid), N'(0));
        @(negedge clk);
        check("resp_vld", N'(rsp_valid), N'(1));
        check("resp_data", rsp_data, exp);
        check("resp_err", N'(rsp_err), N'(err));
        for (int i = 0; i < hold; i++) begin
            ins_valid = 1'b1; ins_op = 3'($urandom); ins_rd = 3'($urandom);
            @(negedge clk);
            check("bp_vld", N'(rsp_valid), N'(1));
            check("bp_data", rsp_data, exp);
            check("bp_err", N'(rsp_err), N'(err));
            check("bp_rdy", N'(ins_ready), N'(0));
            check("bp_op", N'(alu_op), N'(op));
        end
        ins_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        check("post_vld", N'(rsp_valid), N'(0));
        check("post_rdy", N'(ins_ready), N'(1));
        if (!err && rd != 0) model[rd] = exp;
        dbg_chk("wb_dbg", rd, model[rd]);
    endtask

    initial begin
        rst_n = 1'b0; ins_valid = 1'b0; ins_op = '0; ins_rd = '0; ins_rs = '0; ins_rt = '0;
        rsp_ready = 1'b0; dbg_addr = '0;
        for (int i = 0; i < 8; i++) model[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", N'(ins_ready), N'(0));
        check("rst_vld", N'(rsp_valid), N'(0));
        check("rst_r2", alu_r2, '0);
        check("rst_r3", alu_r3, '0);
        check("rst_op", N'(alu_op), '0);
        check("rst_data", rsp_data, '0);
        check("rst_err", N'(rsp_err), '0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("first_idle_rdy", N'(ins_ready), N'(1));
        for (int i = 0; i < 8; i++) dbg_chk("rst_dbg", 3'(i), '0);
        @(negedge clk);

        // Seed constants: r7 = -1, r6 = 1, then r1 = 5, r2 = 7
        run_ins(3'b101, 3'd7, 3'd0, 3'd0, 0);
        run_ins(3'b011, 3'd6, 3'd0, 3'd7, 0);
        run_ins(3'b010, 3'd1, 3'd6, 3'd6, 0);
        run_ins(3'b010, 3'd1, 3'd1, 3'd1, 0);
        run_ins(3'b010, 3'd1, 3'd1, 3'd6, 0);
        run_ins(3'b010, 3'd2, 3'd1, 3'd6, 0);
        run_ins(3'b010, 3'd2, 3'd2, 3'd6, 0);
        dbg_chk("seed_r1", 3'd1, 32'd5);
        dbg_chk("seed_r2", 3'd2, 32'd7);
        run_ins(3'b010, 3'd3, 3'd1, 3'd2, 0);
        dbg_chk("add_12", 3'd3, 32'd12);

        // SUB wrap and SLT with r1 = 3, r2 = 5
        repeat (2) run_ins(3'b011, 3'd1, 3'd1, 3'd6, 0);
        repeat (2) run_ins(3'b011, 3'd2, 3'd2, 3'd6, 0);
        run_ins(3'b011, 3'd4, 3'd1, 3'd2, 0);
        dbg_chk("sub_wrap", 3'd4, 32'hFFFF_FFFE);
        run_ins(3'b110, 3'd5, 3'd1, 3'd2, 0);
        dbg_chk("slt_1", 3'd5, 32'd1);
        run_ins(3'b110, 3'd6, 3'd2, 3'd1, 0);
        dbg_chk("slt_0", 3'd6, 32'd0);

        // Reserved op leaves r3 alone; writes to r0 are dropped
        run_ins(3'b111, 3'd3, 3'd1, 3'd2, 0);
        dbg_chk("rsvd_r3", 3'd3, 32'd12);
        run_ins(3'b010, 3'd0, 3'd1, 3'd2, 0);
        dbg_chk("r0_zero", 3'd0, 32'd0);

        // Backpressure, then immediate next accept
        run_ins(3'b100, 3'd4, 3'd1, 3'd2, 10);
        run_ins(3'b001, 3'd4, 3'd4, 3'd2, 0);

        // Self-overwrite: r2 = 9 then doubling
        repeat (4) run_ins(3'b010, 3'd2, 3'd2, 3'd5, 0);
        dbg_chk("r2_9", 3'd2, 32'd9);
        run_ins(3'b010, 3'd2, 3'd2, 3'd2, 0);
        dbg_chk("self_18", 3'd2, 32'd18);
        run_ins(3'b010, 3'd2, 3'd2, 3'd2, 0);
        dbg_chk("self_36", 3'd2, 32'd36);

        // Randomized instructions against the model
        for (int k = 0; k < 40; k++)
            run_ins(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
                    int'($urandom_range(0, 2)));

        // Reset during EXEC aborts the instruction
        run_ins(3'b010, 3'd3, 3'd2, 3'd2, 0);
        ins_valid = 1'b1; ins_op = 3'b010; ins_rd = 3'd3; ins_rs = 3'd2; ins_rt = 3'd2;
        @(posedge clk); @(negedge clk);
        ins_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 8; i++) model[i] = '0;
        check("abort_vld", N'(rsp_valid), N'(0));
        check("abort_rdy", N'(ins_ready), N'(0));
        check("abort_r2", alu_r2, '0);
        check("abort_r3", alu_r3, '0);
        check("abort_op", N'(alu_op), '0);
        check("abort_data", rsp_data, '0);
        check("abort_err", N'(rsp_err), '0);
        dbg_chk("abort_r3reg", 3'd3, '0);
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort_rdy_after", N'(ins_ready), N'(1));
        check("abort_vld_after", N'(rsp_valid), N'(0));
        @(negedge clk);
        run_ins(3'b101, 3'd1, 3'd0, 3'd0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the team's combinational N-bit ALU: accepts 3-operand instructions over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU's operand and opcode inputs (r2, r3, ALUop), captures the result (r1) and writes it back.
- One instruction in flight at a time; sits between an instruction source and an external Nbit_ALU instance.

Parameters:
- N, 32, data width; must match the ALU's n.
- REG_AW, 3, register-address width; file holds 2**REG_AW registers.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- ins_valid  input  1  instruction offered.
- ins_ready  output  1  controller can accept an instruction.
- ins_op  input  3  ALU opcode.
- ins_rd  input  REG_AW  destination register.
- ins_rs  input  REG_AW  source A, drives alu_r2.
- ins_rt  input  REG_AW  source B, drives alu_r3.
- alu_r2  output  N  operand A to ALU.
- alu_r3  output  N  operand B to ALU.
- alu_op  output  3  opcode to ALU.
- alu_r1  input  N  ALU result; combinational from alu_r2/alu_r3/alu_op.
- rsp_valid  output  1  completion report valid.
- rsp_ready  input  1  consumer accepts the report.
- rsp_data  output  N  result written, or 0 on error.
- rsp_err  output  1  instruction rejected (reserved opcode).
- dbg_addr  input  REG_AW  debug read address.
- dbg_data  output  N  combinational read of the register file; reg 0 reads 0.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; every register = 0; ins_ready=0 during reset and 1 in the first IDLE cycle after; alu_r2=alu_r3=0; alu_op=3'b000; rsp_valid=0; rsp_data=0; rsp_err=0.
- Reset asserted in any state aborts the instruction: no writeback, no response.
- Register 0 always reads 0; writes to it are discarded.
- FSM:
  - IDLE: ins_ready=1. On ins_valid&&ins_ready, latch op/rd/rs/rt and go to ISSUE.
  - ISSUE: alu_r2/alu_r3/alu_op are registered outputs, loaded at the IDLE->ISSUE edge from regfile[rs]/regfile[rt]/op; they hold stable through EXEC. Go to EXEC.
  - EXEC: one settle cycle. At the clock edge, sample alu_r1 into the result register. If op != 3'b111, write regfile[rd]. Go to RESP.
  - RESP: rsp_valid=1 and rsp_data=captured result. rsp_err=1 with rsp_data=0 when op==3'b111, and no write occurs. Hold until rsp_valid&&rsp_ready, then go to IDLE.
- Latency: 4 cycles minimum from accept edge to response handshake (IDLE accept, ISSUE, EXEC, RESP). The next accept comes one cycle after the response handshake. Throughput is 1 instruction per 4 cycles.
- ins_ready=0 in every state except IDLE. ins_* are ignored while not ready.
- rsp_data/rsp_err stay stable while rsp_valid=1 && rsp_ready=0.
- rd==rs or rd==rt is legal: operands are read before the write, so the old value is used.
- Outside ISSUE/EXEC, alu_* hold their last driven value; they are not zeroed.
- Opcodes (shared encoding): 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 NOR, 110 SLT, 111 RESERVED.
  - ADD/SUB wrap modulo 2**N, with no carry/overflow reporting.
  - SLT result is {N-1 zeros, MSB of (A-B)}.
  - The controller treats all opcodes other than 111 opaquely.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_NOR, OP_SLT, OP_RSVD;
  - the state encoding: IDLE=2'd0, ISSUE=2'd1, EXEC=2'd2, RESP=2'd3.
- One natural sub-module: alu_regfile.
  - Two combinational read ports plus the debug port.
  - One synchronous write port with the reg-0 guard.
  - Synchronous active-low reset clearing all entries.
- The FSM and handshake stay in alu_issue_ctrl.
- The bench instantiates the real Nbit_ALU on the alu_* ports.

Test Plan:
- Reset/basic ADD: after reset, dbg reads all 0 and ins_ready=1. Preload r1=5 (ADD rd=1,rs=0,rt=0 yields 0; seed via a chain of ADDs). Then ADD rd=3,rs=1,rt=2 with r1=5, r2=7 -> rsp_data=12, rsp_err=0, dbg_addr=3 reads 12, rsp_valid exactly 3 cycles after accept.
- SUB wrap and SLT: r1=3, r2=5. SUB rd=4,rs=1,rt=2 -> 32'hFFFF_FFFE. SLT rd=5,rs=1,rt=2 -> 1. SLT rd=6,rs=2,rt=1 -> 0.
- Reserved op and r0 guard:
  - op=111, rd=3 -> rsp_err=1, rsp_data=0, r3 unchanged.
  - ADD rd=0 with nonzero sources -> dbg r0 reads 0.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, ins_ready=0, a second ins_valid is not accepted. Release -> next accept happens one cycle later.
- Self-overwrite: r2=9, ADD rd=2,rs=2,rt=2 -> 18. Repeat -> 36.
- Reset mid-op: pull rst_n low during EXEC for an ADD rd=3 -> no response, r3=0, all outputs at reset values, ins_ready=1 the cycle after rst_n returns high.
